mpsoc_msi_wrr_arbiter: RTL and testbench

MPSOC_MSI_WRR_ARBITER -- requirements
Module: mpsoc_msi_wrr_arbiter

---
 rtl/mpsoc_msi_wrr_pkg.sv | 14 +
 rtl/mpsoc_msi_rr_picker.sv | 33 +++
 rtl/mpsoc_msi_wrr_arbiter.sv | 145 ++++++++++++++
 tb/tb_mpsoc_msi_wrr_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mpsoc_msi_wrr_pkg.sv
// Shared definitions for the weighted round-robin MSI arbiter.
// Holds the FSM state type/encoding and the default parameter values.
// No logic; imported by the arbiter top and its picker.
package mpsoc_msi_wrr_pkg;

    localparam int DEFAULT_NUM_PORTS = 6;
    localparam int DEFAULT_WEIGHT_W  = 4;

    // Two-state FSM, encoded as plain constants for compatibility with legacy code.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_GRANT = 1'b1;

endpackage

// File: rtl/mpsoc_msi_rr_picker.sv
// Rotating-priority search: first requesting port at or after start, wrapping.
// Latency: combinational.  Backpressure: none (pure function of inputs).
// Ports: request (per-port), start (search origin) -> found, index (winner).
module mpsoc_msi_rr_picker
    import mpsoc_msi_wrr_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] request,
    input  logic [IDX_W-1:0]     start,
    output logic                 found,
    output logic [IDX_W-1:0]     index
);

    int p;

    // Walk offsets from farthest to nearest so the nearest requester is the
    // last assignment and therefore wins, without needing an early exit.
    always_comb begin
        found = 1'b0;
        index = '0;
        p     = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            p = (int'(start) + k) % NUM_PORTS;
            if (request[p]) begin
                found = 1'b1;
                index = IDX_W'(p);
            end
        end
    end

endmodule

// File: rtl/mpsoc_msi_wrr_arbiter.sv
// Weighted round-robin bus arbiter: each tenure lasts up to weight[i] grant cycles.
// Latency: request sampled at edge n gives registered grant at edge n+1.
// Backpressure: dropping request[owner] releases the grant at the next edge.
// Ports: clk, rst (sync, active-high), request, weight (WEIGHT_W per port),
//        lock (only with MSI_ARB_LOCK_EN defined), grant, selection, active.
// MSI_ARB_LOCK_EN: when defined, lock[owner]=1 extends a tenure past its quota.
module mpsoc_msi_wrr_arbiter
    import mpsoc_msi_wrr_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int WEIGHT_W  = DEFAULT_WEIGHT_W,
    localparam int IDX_W    = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          request,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] weight,
`ifdef MSI_ARB_LOCK_EN
    input  logic [NUM_PORTS-1:0]          lock,
`endif
    output logic [NUM_PORTS-1:0]          grant,
    output logic [IDX_W-1:0]              selection,
    output logic                          active
);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [WEIGHT_W-1:0]  count_q, count_d;
    logic [WEIGHT_W-1:0]  quota_q, quota_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic                 active_q, active_d;

    logic                 owner_lock;
    logic [IDX_W-1:0]     owner_nxt;
    logic [IDX_W-1:0]     search_start;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [WEIGHT_W-1:0]  pick_weight;
    logic [WEIGHT_W-1:0]  pick_quota;
    logic                 hold;
    logic                 launch;

`ifdef MSI_ARB_LOCK_EN
    assign owner_lock = lock[owner_q];
`else
    assign owner_lock = 1'b0;
`endif

    assign owner_nxt = (owner_q == IDX_W'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;

    // While a tenure runs, a re-arbitration (if any) starts just past the owner;
    // from IDLE it starts at the stored pointer.
    assign search_start = (state_q == ST_GRANT) ? owner_nxt : ptr_q;

    mpsoc_msi_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .request (request),
        .start   (search_start),
        .found   (pick_found),
        .index   (pick_idx)
    );

    // A zero weight still earns one grant cycle.
    assign pick_weight = weight[int'(pick_idx)*WEIGHT_W +: WEIGHT_W];
    assign pick_quota  = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;

    assign hold = request[owner_q] && ((count_q < quota_q) || owner_lock);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        count_d  = count_q;
        quota_d  = quota_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        active_d = active_q;
        launch   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                launch = pick_found;
            end
            ST_GRANT: begin
                if (hold) begin
                    count_d = (&count_q) ? count_q : count_q + WEIGHT_W'(1);
                end else begin
                    ptr_d  = owner_nxt;
                    launch = pick_found;
                    if (!pick_found) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        sel_d    = '0;
                        active_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New tenure: grant, selection and active all come from the same pick.
        if (launch) begin
            state_d  = ST_GRANT;
            owner_d  = pick_idx;
            count_d  = WEIGHT_W'(1);
            quota_d  = pick_quota;
            grant_d  = NUM_PORTS'(1) << pick_idx;
            sel_d    = pick_idx;
            active_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            count_q  <= '0;
            quota_q  <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            sel_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            count_q  <= count_d;
            quota_q  <= quota_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            active_q <= active_d;
        end
    end

    assign grant     = grant_q;
    assign selection = sel_q;
    assign active    = active_q;

endmodule

// File: tb/tb_mpsoc_msi_wrr_arbiter.sv
// Bench for the weighted round-robin arbiter (4 ports, 4-bit weights).
// Directed sequences with literal expected grants, then randomized traffic
// compared each cycle against a tenure-level reference model.
module tb_mpsoc_msi_wrr_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   request;
    logic [N*WW-1:0] weight;
    logic [N-1:0]   lock;
    logic [N-1:0]   grant;
    logic [1:0]     selection;
    logic           active;

    int checks = 0;
    int errors = 0;

    // Reference model state: who holds the bus, for how long, and where the
    // next post-tenure search begins.
    bit m_busy;
    int m_owner;
    int m_len;
    int m_quota;
    int m_ptr;

    always #5 clk = ~clk;

    mpsoc_msi_wrr_arbiter #(
        .NUM_PORTS (N),
        .WEIGHT_W  (WW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .request   (request),
        .weight    (weight),
`ifdef MSI_ARB_LOCK_EN
        .lock      (lock),
`endif
        .grant     (grant),
        .selection (selection),
        .active    (active)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int wt(input int i);
        int w;
        w = int'(weight[i*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int find_from(input int start);
        for (int k = 0; k < N; k++) begin
            if (request[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int  w;
        bit  lk;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_len = 0; m_quota = 0; m_ptr = 0;
            return;
        end
`ifdef MSI_ARB_LOCK_EN
        lk = m_busy && lock[m_owner];
`else
        lk = 0;
`endif
        if (!m_busy) begin
            w = find_from(m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_len = 1; m_quota = wt(w);
            end
        end else if (request[m_owner] && (m_len < m_quota || lk)) begin
            if (m_len < 15) m_len++;
        end else begin
            m_ptr = (m_owner + 1) % N;
            w = find_from(m_ptr);
            if (w >= 0) begin
                m_owner = w; m_len = 1; m_quota = wt(w);
            end else begin
                m_busy = 0;
            end
        end
    endtask

    // One clock: advance the model on the edge, then compare just after it.
    task automatic tick();
        logic [N-1:0] eg;
        @(posedge clk);
        model_edge();
        #1;
        eg = m_busy ? (N'(1) << m_owner) : '0;
        check_eq("grant", 32'(grant), 32'(eg));
        check_eq("selection", 32'(selection), m_busy ? 32'(m_owner) : 32'd0);
        check_eq("active", 32'(active), 32'(m_busy));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] seq_a [5];
        logic [N-1:0] seq_b [5];
        int n;

        rst = 1'b1; request = '0; weight = '0; lock = '0;
        m_busy = 0; m_owner = 0; m_len = 0; m_quota = 0; m_ptr = 0;

        // Reset with all ports requesting: outputs stay zero throughout.
        request = 4'b1111;
        weight  = 16'h1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("rst_grant", 32'(grant), 32'd0);
            check_eq("rst_sel", 32'(selection), 32'd0);
            check_eq("rst_active", 32'(active), 32'd0);
        end
        rst = 1'b0;

        // Round robin with unit weights; first grant goes to port 0.
        seq_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("rr_seq", 32'(grant), 32'(seq_a[i]));
        end

        // Weighted: port1 weight 3, port2 weight 0 (treated as 1).
        do_reset();
        request = 4'b0110;
        weight  = 16'h0031;
        seq_b = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("wrr_seq", 32'(grant), 32'(seq_b[i]));
        end

        // Sole requester is re-granted back to back.
        do_reset();
        request = 4'b0001;
        weight  = 16'h0002;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("solo_grant", 32'(grant), 32'h1);
            check_eq("solo_sel", 32'(selection), 32'h0);
        end

        // Dropped request releases early; reset aborts a tenure.
        do_reset();
        request = 4'b0011;
        weight  = 16'h0008;
        tick(); tick();
        check_eq("drop_pre", 32'(grant), 32'h1);
        request = 4'b0010;
        tick();
        check_eq("drop_switch", 32'(grant), 32'h2);
        request = 4'b0011;
        tick();
        rst = 1'b1;
        tick();
        check_eq("mid_rst", 32'(grant), 32'h0);
        check_eq("mid_rst_act", 32'(active), 32'h0);
        rst = 1'b0;

`ifdef MSI_ARB_LOCK_EN
        // Lock keeps port 0 past its unit quota until lock falls.
        do_reset();
        request = 4'b0011;
        weight  = 16'h0001;
        lock    = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("lock_hold", 32'(grant), 32'h1);
        end
        lock = 4'b0000;
        tick();
        check_eq("lock_release", 32'(grant), 32'h2);
`endif

        // Randomized traffic against the model.
        do_reset();
        n = 0;
        for (int c = 0; c < 3000; c++) begin
            request = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) request = '0;
            if ($urandom_range(0, 2) == 0) request = 4'b1111;
            if ($urandom_range(0, 7) == 0) weight = 16'($urandom);
            lock = N'($urandom_range(0, 15));
            rst  = ($urandom_range(0, 199) == 0);
            tick();
            if (active) n++;
        end
        rst = 1'b0;
        check_eq("rand_activity", 32'(n > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
